opl_wr_pacer: RTL and testbench

- Sits directly upstream of the OPL2 core inside the AdLib sound block.
- Captures CPU writes to ports 0x388/0x389 and queues them as {A0, data} pairs in a small FIFO.
- Releases queued writes to the OPL2 core with the minimum register-write recovery gaps enforced, counted in OPL clock-enable ticks.
- Software that writes faster than the OPL timing spec therefore neither loses nor corrupts register writes.

---
 rtl/adlib_pkg.sv | 21 ++
 rtl/opl_wr_fifo.sv | 72 +++++++
 rtl/opl_wr_pacer.sv | 133 +++++++++++++
 tb/tb_opl_wr_pacer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/adlib_pkg.sv
// Shared constants and types for the AdLib sound block: OPL2 port decode,
// register-write recovery gaps and the queued write entry format.
package adlib_pkg;

  localparam logic [11:0] OPL_BASE_ADDR = 12'h388;
  localparam int unsigned OPL_ADDR_GAP  = 12;
  localparam int unsigned OPL_DATA_GAP  = 84;
  localparam int unsigned OPL_ENTRY_W   = 9;

  typedef struct packed {
    logic       a0;
    logic [7:0] din;
  } opl_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } pacer_state_e;

endpackage

// File: rtl/opl_wr_fifo.sv
// Synchronous DEPTH x W FIFO with combinational head output; on a
// simultaneous push/pop the old head is read before the new entry lands.
module opl_wr_fifo
  import adlib_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = OPL_ENTRY_W,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [W-1:0] mem_q [DEPTH];
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  cnt_t         count_q, count_d;
  logic         do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == cnt_t'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/opl_wr_pacer.sv
// Queues CPU writes to 0x388/0x389 and releases them to the OPL2 core with
// register-write recovery gaps counted in cen ticks. Optional: OPL_WR_PACER_BYPASS_EN.
module opl_wr_pacer
  import adlib_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_GAP = OPL_ADDR_GAP,
  parameter int unsigned DATA_GAP = OPL_DATA_GAP
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iClkEn,
  input  logic        iWr,
  input  logic [7:0]  iWrData,
  input  logic [19:0] iAddr,
  output logic        oOplWr,
  output logic        oOplA0,
  output logic [7:0]  oOplDin,
  output logic        oBusy,
  output logic        oOverflow
`ifdef OPL_WR_PACER_BYPASS_EN
  ,
  input  logic        iBypass
`endif
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned GAP_MAX = (DATA_GAP > ADDR_GAP) ? DATA_GAP : ADDR_GAP;
  localparam int unsigned GW      = $clog2(GAP_MAX) + 1;

  typedef logic [GW-1:0] gap_t;
  typedef logic [AW:0]   cnt_t;

  pacer_state_e state_q, state_d;
  gap_t         gap_q, gap_d;
  opl_entry_t   last_q, last_d;
  opl_entry_t   head, wr_ent;
  logic         ovf_q, ovf_d;
  logic         busy_q, busy_d;
  logic         sel, bypass, issue, push, pop;
  logic         fifo_full, fifo_empty;
  cnt_t         fifo_cnt, cnt_nxt;
  logic         unused_addr;

`ifdef OPL_WR_PACER_BYPASS_EN
  assign bypass = iBypass;
`else
  assign bypass = 1'b0;
`endif

  assign unused_addr = ^iAddr[19:12];
  assign sel    = iWr && ({iAddr[11:1], 1'b0} == OPL_BASE_ADDR);
  assign wr_ent = opl_entry_t'({iAddr[0], iWrData});

  // Issuing on the expiring GAP tick itself keeps strobe-to-strobe spacing
  // exactly equal to the gap, with no idle tick between queued writes.
  assign issue = !bypass && iClkEn && !fifo_empty &&
                 ((state_q != ST_GAP) || (gap_q == '0));
  assign pop   = issue;
  assign push  = sel && !bypass && (!fifo_full || pop);

  opl_wr_fifo #(
    .DEPTH (DEPTH),
    .W     (OPL_ENTRY_W)
  ) u_fifo (
    .clk_i   (iClk),
    .rst_ni  (iRst),
    .flush_i (bypass),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (wr_ent),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_ISSUE;
      ST_GAP: begin
        if (iClkEn) begin
          if (gap_q == '0) state_d = ST_IDLE;
          else             gap_d   = gap_q - gap_t'(1);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    if (issue) begin
      state_d = ST_GAP;
      gap_d   = head.a0 ? gap_t'(DATA_GAP - 1) : gap_t'(ADDR_GAP - 1);
    end
    if (bypass) begin
      state_d = ST_IDLE;
      gap_d   = '0;
    end
  end

  always_comb begin
    cnt_nxt = fifo_cnt + cnt_t'(push) - cnt_t'(pop);
    ovf_d   = ovf_q || (sel && !bypass && fifo_full && !pop);
    busy_d  = !bypass && ((cnt_nxt != '0) || (state_d != ST_IDLE));
    last_d  = last_q;
    if (issue)              last_d = head;
    else if (bypass && sel) last_d = wr_ent;
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign oOplWr    = bypass ? sel : issue;
  assign oOplA0    = last_d.a0;
  assign oOplDin   = last_d.din;
  assign oBusy     = busy_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_opl_wr_pacer.sv
// Self-checking bench for opl_wr_pacer: queue/tick-budget reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_opl_wr_pacer;

  localparam int DEPTH = 8;
  localparam int AG    = 12;
  localparam int DG    = 84;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        iClkEn = 1'b0;
  logic        iWr = 1'b0;
  logic [7:0]  iWrData = '0;
  logic [19:0] iAddr = '0;
  logic        oOplWr, oOplA0, oBusy, oOverflow;
  logic [7:0]  oOplDin;

  int checks = 0;
  int failures = 0;

  always #5 iClk = ~iClk;

  opl_wr_pacer #(
    .DEPTH    (DEPTH),
    .ADDR_GAP (AG),
    .DATA_GAP (DG)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iClkEn    (iClkEn),
    .iWr       (iWr),
    .iWrData   (iWrData),
    .iAddr     (iAddr),
    .oOplWr    (oOplWr),
    .oOplA0    (oOplA0),
    .oOplDin   (oOplDin),
    .oBusy     (oBusy),
    .oOverflow (oOverflow)
  );

  // cen: one pulse every 3rd system clock
  int cyc = 0;
  initial forever begin
    @(posedge iClk);
    #1;
    cyc++;
    iClkEn = (cyc % 3 == 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending writes plus remaining gap ticks.
  logic [8:0] mq[$];
  int         rem = 0;
  logic [8:0] mlast = '0;
  bit         movf = 0;
  int         tick_idx = 0;
  int         pulses = 0;
  int         last_pulse_idx = 0;
  int         spacing = 0;
  int         busy_ticks = 0;
  logic [8:0] pulse_val = '0;

  always @(negedge iClk) begin
    bit         msel, missue;
    logic [8:0] hv;
    if (iRst) begin
      msel   = iWr && ((iAddr[11:0] == 12'h388) || (iAddr[11:0] == 12'h389));
      missue = iClkEn && (mq.size() != 0) && (rem <= 1);
      hv     = missue ? mq[0] : mlast;
      chk("model_wr",   oOplWr,    missue);
      chk("model_a0",   oOplA0,    hv[8]);
      chk("model_din",  oOplDin,   hv[7:0]);
      chk("model_busy", oBusy,     (mq.size() != 0) || (rem != 0));
      chk("model_ovf",  oOverflow, movf);
      if (missue) begin
        void'(mq.pop_front());
        mlast = hv;
        rem   = hv[8] ? DG : AG;
      end else if (iClkEn && rem > 0) begin
        rem--;
      end
      if (msel) begin
        if (mq.size() < DEPTH) mq.push_back({iAddr[0], iWrData});
        else                   movf = 1;
      end
    end else begin
      mq.delete();
      rem   = 0;
      mlast = '0;
      movf  = 0;
    end
    if (oOplWr) begin
      pulses++;
      spacing        = tick_idx - last_pulse_idx;
      last_pulse_idx = tick_idx;
      pulse_val      = {oOplA0, oOplDin};
      busy_ticks     = 0;
    end else if (iClkEn && oBusy) begin
      busy_ticks++;
    end
    if (iClkEn) tick_idx++;
  end

  task automatic step();
    @(posedge iClk);
    #2;
  endtask

  task automatic wr(input logic [19:0] a, input logic [7:0] d);
    iWr = 1'b1; iAddr = a; iWrData = d;
    step();
    iWr = 1'b0;
  endtask

  task automatic do_reset();
    iRst = 1'b0;
    step();
    iRst = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (oBusy && n < max) begin step(); n++; end
    chk(name, oBusy, 0);
  endtask

  task automatic wait_pulses(input string name, input int want, input int max);
    int n = 0;
    while (pulses < want && n < max) begin step(); n++; end
    chk(name, pulses, want);
  endtask

  initial begin
    repeat (4) @(posedge iClk);
    #2;
    iRst = 1'b1;
    chk("rst_wr",   oOplWr,    0);
    chk("rst_a0",   oOplA0,    0);
    chk("rst_din",  oOplDin,   0);
    chk("rst_busy", oBusy,     0);
    chk("rst_ovf",  oOverflow, 0);

    // single address write
    pulses = 0;
    wr(20'h00388, 8'h20);
    wait_idle("t1_idle", 300);
    chk("t1_pulses", pulses, 1);
    chk("t1_val", pulse_val, 9'h020);
    chk("t1_busy_ticks", busy_ticks, AG);

    // address then data back-to-back
    pulses = 0;
    wr(20'h00388, 8'hB0);
    wr(20'h00389, 8'h31);
    wait_idle("t2_idle", 600);
    chk("t2_pulses", pulses, 2);
    chk("t2_spacing", spacing, AG);
    chk("t2_val", pulse_val, 9'h131);
    chk("t2_busy_ticks", busy_ticks, DG);

    // nine pushes during a gap: eighth fills, ninth dropped
    pulses = 0;
    wr(20'h00388, 8'h01);
    wait_pulses("t3_first", 1, 100);
    for (int i = 0; i < 9; i++) wr(20'h00389, 8'h10 + 8'(i));
    chk("t3_ovf_set", oOverflow, 1);
    wait_idle("t3_idle", 5000);
    chk("t3_pulses", pulses, 9);
    chk("t3_last", pulse_val, 9'h117);
    chk("t3_ovf_sticky", oOverflow, 1);
    do_reset();
    chk("t3_ovf_clr", oOverflow, 0);

    // full FIFO, push coincident with pop
    pulses = 0;
    wr(20'h00388, 8'h03);
    wait_pulses("t4_first", 1, 100);
    for (int i = 0; i < 8; i++) wr(20'h00389, 8'h40 + 8'(i));
    begin
      int n = 0;
      while (!(iClkEn && (tick_idx - last_pulse_idx) == AG) && n < 100) begin
        step(); n++;
      end
      iWr = 1'b1; iAddr = 20'h00389; iWrData = 8'h48;
      step();
      iWr = 1'b0;
    end
    chk("t4_ovf", oOverflow, 0);
    wait_idle("t4_idle", 5000);
    chk("t4_pulses", pulses, 10);
    chk("t4_last", pulse_val, 9'h148);
    chk("t4_ovf_end", oOverflow, 0);

    // decode: only iAddr[11:0] matters
    pulses = 0;
    wr(20'h0038A, 8'h11);
    wr(20'h00288, 8'h22);
    repeat (3) step();
    chk("t5_busy", oBusy, 0);
    chk("t5_none", pulses, 0);
    wr(20'h01388, 8'h55);
    wait_idle("t5_idle", 300);
    chk("t5_pulses", pulses, 1);
    chk("t5_val", pulse_val, 9'h055);

    // reset in GAP with three entries queued
    pulses = 0;
    wr(20'h00388, 8'h60);
    wait_pulses("t6_first", 1, 100);
    for (int i = 0; i < 3; i++) wr(20'h00389, 8'h70 + 8'(i));
    repeat (5) step();
    do_reset();
    chk("t6_wr",   oOplWr,    0);
    chk("t6_a0",   oOplA0,    0);
    chk("t6_din",  oOplDin,   0);
    chk("t6_busy", oBusy,     0);
    chk("t6_ovf",  oOverflow, 0);
    pulses = 0;
    repeat (600) step();
    chk("t6_no_pulse", pulses, 0);
    chk("t6_busy_end", oBusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
